// File: rtl/roce_mem_cmd_splitter.sv
// Splits memory commands into chunks that never cross a 2^BOUNDARY_W-byte boundary.
// Each chunk keeps the original dest; last marks the final chunk of a command.
module roce_mem_cmd_splitter #(
  parameter int BOUNDARY_W = 12,
  parameter int DEST_W     = 1
) (
  input  logic              net_clk,
  input  logic              net_areset,
  input  logic              s_axis_cmd_valid,
  output logic              s_axis_cmd_ready,
  input  logic [95:0]       s_axis_cmd_data,
  input  logic [DEST_W-1:0] s_axis_cmd_dest,
  output logic              m_axis_cmd_valid,
  input  logic              m_axis_cmd_ready,
  output logic [95:0]       m_axis_cmd_data,
  output logic [DEST_W-1:0] m_axis_cmd_dest,
  output logic              m_axis_cmd_last,
  output logic [31:0]       zero_len_drop_count
);

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t              state_reg;
  logic [63:0]         cur_addr_reg;
  logic [31:0]         rem_reg;
  logic [DEST_W-1:0]   dest_reg;
  logic                m_valid_reg;
  logic [95:0]         m_data_reg;
  logic [DEST_W-1:0]   m_dest_reg;
  logic                m_last_reg;
  logic [31:0]         drop_cnt_reg;

  logic                slot_free;
  logic [63:0]         src_addr;
  logic [31:0]         src_len;
  logic [32:0]         room;
  logic [31:0]         chunk;
  logic [63:0]         next_addr;
  logic [31:0]         next_rem;
  logic                is_last;

  assign slot_free        = !m_valid_reg || m_axis_cmd_ready;
  assign s_axis_cmd_ready = (state_reg == IDLE) && slot_free;

  // One chunk calculator shared by the accept path and the split path.
  always_comb begin
    src_addr  = (state_reg == IDLE) ? s_axis_cmd_data[63:0]  : cur_addr_reg;
    src_len   = (state_reg == IDLE) ? s_axis_cmd_data[95:64] : rem_reg;
    room      = (33'd1 << BOUNDARY_W) - {{(33-BOUNDARY_W){1'b0}}, src_addr[BOUNDARY_W-1:0]};
    chunk     = (room > {1'b0, src_len}) ? src_len : room[31:0];
    next_addr = src_addr + {32'd0, chunk};
    next_rem  = src_len - chunk;
    is_last   = (src_len == chunk);
  end

  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      state_reg    <= IDLE;
      cur_addr_reg <= '0;
      rem_reg      <= '0;
      dest_reg     <= '0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
      m_dest_reg   <= '0;
      m_last_reg   <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (s_axis_cmd_valid && slot_free) begin
            if (src_len == 32'd0) begin
              m_valid_reg <= 1'b0;
              if (drop_cnt_reg != 32'hFFFF_FFFF)
                drop_cnt_reg <= drop_cnt_reg + 32'd1;
            end else begin
              m_valid_reg  <= 1'b1;
              m_data_reg   <= {chunk, src_addr};
              m_dest_reg   <= s_axis_cmd_dest;
              m_last_reg   <= is_last;
              cur_addr_reg <= next_addr;
              rem_reg      <= next_rem;
              dest_reg     <= s_axis_cmd_dest;
              if (!is_last)
                state_reg <= SPLIT;
            end
          end else if (slot_free) begin
            m_valid_reg <= 1'b0;
          end
        end
        SPLIT: begin
          if (slot_free) begin
            m_valid_reg  <= 1'b1;
            m_data_reg   <= {chunk, src_addr};
            m_dest_reg   <= dest_reg;
            m_last_reg   <= is_last;
            cur_addr_reg <= next_addr;
            rem_reg      <= next_rem;
            if (is_last)
              state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis_cmd_valid    = m_valid_reg;
  assign m_axis_cmd_data     = m_data_reg;
  assign m_axis_cmd_dest     = m_dest_reg;
  assign m_axis_cmd_last     = m_last_reg;
  assign zero_len_drop_count = drop_cnt_reg;

endmodule

// File: tb/tb_roce_mem_cmd_splitter.sv
// Scoreboard bench for roce_mem_cmd_splitter with the default 4 KiB boundary.
module tb_roce_mem_cmd_splitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [95:0] s_data = '0;
  logic [1:0]  s_dest = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [95:0] m_data;
  logic [1:0]  m_dest;
  logic        m_last;
  logic [31:0] drop_cnt;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] len;
    logic [1:0]  dest;
    logic        last;
  } chunk_t;

  chunk_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  roce_mem_cmd_splitter #(.BOUNDARY_W(12), .DEST_W(2)) dut (
    .net_clk             (clk),
    .net_areset          (rst),
    .s_axis_cmd_valid    (s_valid),
    .s_axis_cmd_ready    (s_ready),
    .s_axis_cmd_data     (s_data),
    .s_axis_cmd_dest     (s_dest),
    .m_axis_cmd_valid    (m_valid),
    .m_axis_cmd_ready    (m_ready),
    .m_axis_cmd_data     (m_data),
    .m_axis_cmd_dest     (m_dest),
    .m_axis_cmd_last     (m_last),
    .zero_len_drop_count (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [31:0] l, input logic [1:0] d, input logic lst);
    chunk_t c;
    c.addr = a; c.len = l; c.dest = d; c.last = lst;
    exp_q.push_back(c);
  endtask

  // Called at a negedge; returns at (or just after) the negedge following acceptance.
  task automatic send(input logic [63:0] a, input logic [31:0] l, input logic [1:0] d, output int waits);
    bit accepted = 0;
    waits = 0;
    s_valid = 1'b1;
    s_data  = {l, a};
    s_dest  = d;
    for (int i = 0; i < 100 && !accepted; i++) begin
      #1;
      if (s_ready) accepted = 1;
      else waits++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    if (!accepted) check("accept_timeout", 0, 1);
    $display("cmd addr=0x%0h len=0x%0h dest=%0d waits=%0d", a, l, d, waits);
    #1;
    if (l != 0) check("latency_valid", m_valid, 1);
    else        check("zero_no_valid", m_valid, 0);
  endtask

  // Monitor: sample between edges, the handshake happens at the next posedge.
  always @(negedge clk) begin
    #3;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_chunk", m_data, 0);
      end else begin
        chunk_t e;
        e = exp_q.pop_front();
        $display("chunk addr=0x%0h len=0x%0h dest=%0d last=%0d", m_data[63:0], m_data[95:64], m_dest, m_last);
        check("chunk_addr", m_data[63:0], e.addr);
        check("chunk_len",  m_data[95:64], e.len);
        check("chunk_dest", m_dest, e.dest);
        check("chunk_last", m_last, e.last);
      end
    end
  end

  initial begin
    int w;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ready", s_ready, 1);
    @(negedge clk);

    // Single chunk
    push(64'h1000, 32'h100, 2'd0, 1'b1);
    send(64'h1000, 32'h100, 2'd0, w);
    check("single_waits", w, 0);

    // Boundary straddle
    push(64'h0F80, 32'h80,  2'd2, 1'b0);
    push(64'h1000, 32'h180, 2'd2, 1'b1);
    send(64'h0F80, 32'h200, 2'd2, w);

    // Three full pages; ready low for one cycle after the straddle accept
    push(64'h2000, 32'h1000, 2'd1, 1'b0);
    push(64'h3000, 32'h1000, 2'd1, 1'b0);
    push(64'h4000, 32'h1000, 2'd1, 1'b1);
    send(64'h2000, 32'h3000, 2'd1, w);
    check("straddle_ready_low", w, 1);

    // Accepted in the cycle the third page handshakes
    push(64'h8000, 32'h40, 2'd3, 1'b1);
    send(64'h8000, 32'h40, 2'd3, w);
    check("pages_ready_low", w, 2);

    // Zero length drop
    send(64'h1234, 32'h0, 2'd0, w);
    check("zero_waits", w, 0);
    check("drop_cnt_1", drop_cnt, 1);

    // Saturation
    @(negedge clk);
    force dut.drop_cnt_reg = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.drop_cnt_reg;
    send(64'h0, 32'h0, 2'd0, w);
    check("drop_cnt_max", drop_cnt, 32'hFFFF_FFFF);
    send(64'h0, 32'h0, 2'd0, w);
    check("drop_cnt_sat", drop_cnt, 32'hFFFF_FFFF);

    // Backpressure across the 2^64 wrap
    @(negedge clk);
    m_ready = 1'b0;
    push(64'hFFFF_FFFF_FFFF_FFC0, 32'h40, 2'd2, 1'b0);
    push(64'h0,                  32'h40, 2'd2, 1'b1);
    send(64'hFFFF_FFFF_FFFF_FFC0, 32'h80, 2'd2, w);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", m_valid, 1);
      check("bp_addr", m_data[63:0], 64'hFFFF_FFFF_FFFF_FFC0);
      check("bp_len", m_data[95:64], 32'h40);
      check("bp_last", m_last, 0);
      check("bp_ready_low", s_ready, 0);
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during chunk 2 of 3
    push(64'h2000, 32'h1000, 2'd1, 1'b0);
    send(64'h2000, 32'h3000, 2'd1, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_ready", s_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", m_valid, 0);
    push(64'h5000, 32'h10, 2'd3, 1'b1);
    send(64'h5000, 32'h10, 2'd3, w);
    repeat (5) @(negedge clk);
    check("post_rst_quiet", m_valid, 0);
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
